// File: rtl/pkt_burst_writer_pkg.sv
// Shared types, header layout and beat-size helper for the packet burst writer.
package pkt_wr_pkg;

  typedef enum logic [2:0] {StIdle, StHdr, StWaitData, StData, StDone} wr_state_e;

  localparam int unsigned HDR_BITS    = 128;
  localparam int unsigned HDR_SEC_LSB = 0;
  localparam int unsigned HDR_NS_LSB  = 32;
  localparam int unsigned HDR_LEN_LSB = 64;

  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Upper 48 bits stay zero.
  function automatic logic [HDR_BITS-1:0] build_header(input logic [15:0] len,
                                                       input logic [31:0] ns,
                                                       input logic [31:0] sec);
    logic [HDR_BITS-1:0] h;
    h = '0;
    h[HDR_SEC_LSB +: 32] = sec;
    h[HDR_NS_LSB  +: 32] = ns;
    h[HDR_LEN_LSB +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/pkt_burst_writer_if.sv
// Avalon-MM write host signals plus the show-ahead FIFO read port.
interface pkt_burst_writer_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned USEDW_W   = 9
);
  localparam int unsigned BC_W = $clog2(MAX_BURST) + 1;

  logic [ADDR_W-1:0]  address;
  logic [DATA_W-1:0]  writedata;
  logic               write;
  logic [BC_W-1:0]    burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  fifo_data;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_rd;

  modport master (
    output address, writedata, write, burstcount, fifo_rd,
    input  waitrequest, fifo_data, fifo_usedw
  );

  modport slave (
    input  address, writedata, write, burstcount, fifo_rd,
    output waitrequest, fifo_data, fifo_usedw
  );
endinterface

// File: rtl/pkt_burst_writer_planner.sv
// Computes the address after the current burst (with ring wrap) and the length of
// the burst that starts there.
module burst_planner
  import pkt_wr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BC_W      = $clog2(MAX_BURST) + 1
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [BC_W-1:0]   cur_len,
  input  logic [15:0]       beats_left,
  input  logic [ADDR_W-1:0] ring_base,
  input  logic [ADDR_W-1:0] ring_size,
  output logic [ADDR_W-1:0] next_addr,
  output logic [BC_W-1:0]   next_len
);
  localparam int unsigned BpbLog = $clog2(bytes_per_beat(DATA_W));

  logic [ADDR_W-1:0] ring_end, sum, room, lim;

  always_comb begin
    ring_end  = ring_base + ring_size;
    sum       = cur_addr + (ADDR_W'(cur_len) << BpbLog);
    next_addr = (sum >= ring_end) ? ring_base : sum;
    room      = (ring_end - next_addr) >> BpbLog;
    lim       = ADDR_W'(MAX_BURST);
    if (ADDR_W'(beats_left) < lim) lim = ADDR_W'(beats_left);
    if (room < lim) lim = room;
    next_len  = BC_W'(lim);
  end
endmodule

// File: rtl/pkt_burst_writer.sv
// Writes a 128-bit timestamp header then the packet payload from a show-ahead FIFO
// into a byte-addressed ring buffer as Avalon-MM bursts.
module pkt_burst_writer
  import pkt_wr_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned USEDW_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        pkt_len,
  input  logic [31:0]        seconds,
  input  logic [31:0]        nanoseconds,
  input  logic [ADDR_W-1:0]  ring_base,
  input  logic [ADDR_W-1:0]  ring_size,
  output logic [ADDR_W-1:0]  wr_ptr,
  output logic               busy,
  output logic               done,
  pkt_burst_writer_if.master bus
);
  localparam int unsigned BC_W      = $clog2(MAX_BURST) + 1;
  localparam int unsigned BPB       = bytes_per_beat(DATA_W);
  localparam int unsigned BpbLog    = $clog2(BPB);
  localparam int unsigned HDR_BEATS = HDR_BITS / DATA_W;
  localparam int unsigned HIDX_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  wr_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d, beats_left_q, beats_left_d;
  logic [31:0]       sec_q, sec_d, ns_q, ns_d;
  logic [ADDR_W-1:0] base_q, base_d, size_q, size_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
  logic              ptr_valid_q, ptr_valid_d;
  logic [BC_W-1:0]   bc_q, bc_d, beat_cnt_q, beat_cnt_d;
  logic [HIDX_W-1:0] hdr_idx_q, hdr_idx_d;

  logic [HDR_BITS-1:0] header;
  logic [16:0]         len_round;
  logic [15:0]         total_beats;
  logic                advance;
  logic [ADDR_W-1:0]   next_addr;
  logic [BC_W-1:0]     next_len;

  assign header      = build_header(len_q, ns_q, sec_q);
  assign len_round   = {1'b0, pkt_len} + 17'(BPB - 1);
  assign total_beats = 16'(len_round >> BpbLog);

  burst_planner #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .BC_W      (BC_W)
  ) u_planner (
    .cur_addr   (addr_q),
    .cur_len    (bc_q),
    .beats_left (beats_left_q),
    .ring_base  (base_q),
    .ring_size  (size_q),
    .next_addr  (next_addr),
    .next_len   (next_len)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sec_d         = sec_q;
    ns_d          = ns_q;
    base_d        = base_q;
    size_d        = size_q;
    wr_ptr_d      = wr_ptr_q;
    addr_d        = addr_q;
    ptr_valid_d   = ptr_valid_q;
    bc_d          = bc_q;
    beat_cnt_d    = beat_cnt_q;
    beats_left_d  = beats_left_q;
    hdr_idx_d     = hdr_idx_q;
    advance       = 1'b0;
    bus.write     = 1'b0;
    bus.fifo_rd   = 1'b0;
    bus.writedata = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d        = pkt_len;
          sec_d        = seconds;
          ns_d         = nanoseconds;
          base_d       = ring_base;
          size_d       = ring_size;
          addr_d       = ptr_valid_q ? wr_ptr_q : ring_base;
          wr_ptr_d     = addr_d;
          ptr_valid_d  = 1'b1;
          bc_d         = BC_W'(HDR_BEATS);
          beat_cnt_d   = BC_W'(HDR_BEATS);
          hdr_idx_d    = '0;
          beats_left_d = total_beats;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        bus.write     = 1'b1;
        bus.writedata = header[hdr_idx_q * DATA_W +: DATA_W];
        if (!bus.waitrequest) begin
          hdr_idx_d = hdr_idx_q + 1'b1;
          advance   = 1'b1;
        end
      end
      StWaitData: begin
        if (32'(bus.fifo_usedw) >= 32'(bc_q)) state_d = StData;
      end
      StData: begin
        bus.write     = 1'b1;
        bus.writedata = bus.fifo_data;
        bus.fifo_rd   = !bus.waitrequest;
        advance       = !bus.waitrequest;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // beats_left counts payload beats not yet assigned to a planned burst.
    if (advance) begin
      beat_cnt_d = beat_cnt_q - 1'b1;
      if (beat_cnt_q == BC_W'(1)) begin
        addr_d = next_addr;
        if (beats_left_q == '0) begin
          wr_ptr_d = next_addr;
          state_d  = StDone;
        end else begin
          bc_d         = next_len;
          beat_cnt_d   = next_len;
          beats_left_d = beats_left_q - 16'(next_len);
          state_d      = StWaitData;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      sec_q        <= '0;
      ns_q         <= '0;
      base_q       <= '0;
      size_q       <= '0;
      wr_ptr_q     <= '0;
      addr_q       <= '0;
      ptr_valid_q  <= 1'b0;
      bc_q         <= '0;
      beat_cnt_q   <= '0;
      beats_left_q <= '0;
      hdr_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sec_q        <= sec_d;
      ns_q         <= ns_d;
      base_q       <= base_d;
      size_q       <= size_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      ptr_valid_q  <= ptr_valid_d;
      bc_q         <= bc_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_left_q <= beats_left_d;
      hdr_idx_q    <= hdr_idx_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.burstcount = bc_q;
  assign wr_ptr         = wr_ptr_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
endmodule

// File: tb/tb_pkt_burst_writer.sv
// Scoreboard bench: a model plans bursts/beats per packet, an Avalon slave + FIFO
// model checks every beat the writer emits.
module tb_pkt_burst_writer;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned USEDW_W   = 9;
  localparam logic [31:0] RING_BASE = 32'h1000;
  localparam logic [31:0] RING_SIZE = 32'h1000;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [15:0] pkt_len;
  logic [31:0] seconds, nanoseconds, ring_base, ring_size, wr_ptr;

  pkt_burst_writer_if #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W),
                        .USEDW_W(USEDW_W)) bus ();

  pkt_burst_writer #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W),
                     .USEDW_W(USEDW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .seconds(seconds),
    .nanoseconds(nanoseconds), .ring_base(ring_base), .ring_size(ring_size),
    .wr_ptr(wr_ptr), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int len; } burst_t;
  typedef struct { logic [31:0] data; bit is_data; } beat_t;

  burst_t      exp_bursts[$];
  beat_t       exp_beats[$];
  logic [31:0] fifo_q[$];
  logic [31:0] pend_q[$];
  int feed_cap = 256, stall_at = -1, stall_len = 0, stall_done = 0;
  int acc_beats = 0, rd_count = 0, exp_rd = 0;
  int n_tests = 0, n_fail = 0;
  logic [31:0] model_ptr = '0;
  bit model_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ring_next(input logic [31:0] a, input int beats);
    logic [31:0] n;
    n = a + 32'(beats * 4);
    if (n >= RING_BASE + RING_SIZE) n = RING_BASE;
    return n;
  endfunction

  // Avalon slave monitor and show-ahead FIFO model.
  initial begin : slave_side
    burst_t cur;
    beat_t  b;
    int     left;
    bit     pop;
    logic [31:0] tmp;
    cur = '{addr: 32'h0, len: 0};
    left = 0;
    bus.waitrequest = 1'b0;
    bus.fifo_data   = '0;
    bus.fifo_usedw  = '0;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (reset) begin
        left = 0;
      end else begin
        if (bus.fifo_rd) begin
          rd_count++;
          pop = 1'b1;
        end
        if (bus.write) begin
          if (left == 0) begin
            check_eq("burst_pending", 32'(exp_bursts.size() != 0), 32'd1);
            if (exp_bursts.size() != 0) begin
              cur  = exp_bursts.pop_front();
              left = cur.len;
              check_eq("burst_addr", bus.address, cur.addr);
              check_eq("burst_len", 32'(bus.burstcount), 32'(cur.len));
            end
          end else begin
            check_eq("addr_hold", bus.address, cur.addr);
            check_eq("len_hold", 32'(bus.burstcount), 32'(cur.len));
          end
          check_eq("beat_pending", 32'(exp_beats.size() != 0), 32'd1);
          if (exp_beats.size() != 0) begin
            check_eq("wdata", bus.writedata, exp_beats[0].data);
            if (bus.waitrequest) begin
              check_eq("fifo_rd_stall", 32'(bus.fifo_rd), 32'd0);
              stall_done++;
            end else begin
              b = exp_beats.pop_front();
              check_eq("fifo_rd", 32'(bus.fifo_rd), 32'(b.is_data));
              if (left > 0) left--;
              acc_beats++;
            end
          end
        end else begin
          check_eq("write_gap", 32'(left), 32'd0);
          check_eq("fifo_rd_idle", 32'(bus.fifo_rd), 32'd0);
        end
      end
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() != 0) tmp = fifo_q.pop_front();
      while (fifo_q.size() < feed_cap && pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
      bus.fifo_data   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      bus.fifo_usedw  = USEDW_W'(fifo_q.size());
      bus.waitrequest = (acc_beats == stall_at) && (stall_done < stall_len);
    end
  end

  // Plans expected bursts/beats, queues payload for the FIFO and pulses start.
  task automatic send_pkt(input logic [15:0] len, input int cap);
    logic [31:0] addr, sec, ns, w, room;
    int rem, blen;
    sec = $urandom;
    ns  = $urandom;
    if (!model_valid) begin
      model_ptr   = RING_BASE;
      model_valid = 1'b1;
    end
    addr = model_ptr;
    exp_bursts.push_back('{addr: addr, len: 4});
    exp_beats.push_back('{data: sec, is_data: 1'b0});
    exp_beats.push_back('{data: ns, is_data: 1'b0});
    exp_beats.push_back('{data: {16'h0, len}, is_data: 1'b0});
    exp_beats.push_back('{data: 32'h0, is_data: 1'b0});
    addr = ring_next(addr, 4);
    rem  = (int'(len) + 3) / 4;
    exp_rd = rem;
    for (int i = 0; i < rem; i++) begin
      w = $urandom;
      pend_q.push_back(w);
      exp_beats.push_back('{data: w, is_data: 1'b1});
    end
    while (rem > 0) begin
      blen = MAX_BURST;
      if (rem < blen) blen = rem;
      room = (RING_BASE + RING_SIZE - addr) / 4;
      if (room < 32'(blen)) blen = int'(room);
      exp_bursts.push_back('{addr: addr, len: blen});
      addr = ring_next(addr, blen);
      rem -= blen;
    end
    model_ptr  = addr;
    acc_beats  = 0;
    stall_done = 0;
    rd_count   = 0;
    feed_cap   = cap;
    start = 1'b1; pkt_len = len; seconds = sec; nanoseconds = ns;
    ring_base = RING_BASE; ring_size = RING_SIZE;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, fires an ignored start in the done cycle, then checks idle.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("busy_at_done", 32'(busy), 32'd1);
      check_eq("wr_ptr", wr_ptr, model_ptr);
      start = 1'b1;
      pkt_len = 16'd8;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check_eq("start_in_done_ignored", 32'(busy), 32'd0);
      check_eq("bursts_left", 32'(exp_bursts.size()), 32'd0);
      check_eq("beats_left", 32'(exp_beats.size()), 32'd0);
      check_eq("fifo_rd_count", 32'(rd_count), 32'(exp_rd));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit seen;
    reset = 1'b1; start = 1'b0; pkt_len = '0; seconds = '0; nanoseconds = '0;
    ring_base = '0; ring_size = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr_ptr", wr_ptr, 32'd0);
    check_eq("rst_write", 32'(bus.write), 32'd0);
    check_eq("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    check_eq("rst_address", bus.address, 32'd0);
    check_eq("rst_burstcount", 32'(bus.burstcount), 32'd0);
    check_eq("rst_writedata", bus.writedata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    send_pkt(16'd64, 256);
    wait_done();
    check_eq("first_pkt_ptr", wr_ptr, 32'h1050);

    send_pkt(16'd3984, 256);
    wait_done();
    check_eq("near_end_ptr", wr_ptr, 32'h1FF0);

    send_pkt(16'd64, 256);
    wait_done();
    check_eq("wrap_ptr", wr_ptr, 32'h1040);

    send_pkt(16'd5, 256);
    wait_done();
    check_eq("short_rd_pulses", 32'(rd_count), 32'd2);

    stall_at = 6;
    stall_len = 3;
    send_pkt(16'd32, 256);
    wait_done();
    check_eq("stall_cycles", 32'(stall_done), 32'd3);
    stall_at = -1;
    stall_len = 0;

    send_pkt(16'd0, 256);
    wait_done();
    check_eq("zero_len_ptr", wr_ptr, 32'h1098);

    send_pkt(16'd64, 10);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("usedw_hold_write", 32'(bus.write), 32'd0);
      check_eq("usedw_hold_level", 32'(bus.fifo_usedw), 32'd10);
    end
    feed_cap = 256;
    wait_done();

    send_pkt(16'd256, 256);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (acc_beats >= 8 && bus.write) seen = 1'b1;
    end
    check_eq("mid_burst_reached", 32'(seen), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_write", 32'(bus.write), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_wr_ptr", wr_ptr, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_bursts.delete();
    exp_beats.delete();
    fifo_q.delete();
    pend_q.delete();
    model_valid = 1'b0;

    send_pkt(16'd64, 256);
    wait_done();
    check_eq("post_reset_ptr", wr_ptr, 32'h1050);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
